// File: rtl/nubus_sched_pkg.sv
// Shared types and defaults for the NuBus master-port scheduler.
package nubus_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_RESP  = 2'd2,
        ST_LHOLD = 2'd3
    } sched_state_e;

    localparam int NREQ_MAX      = 4;
    localparam int TMO_W_DEF     = 8;
    localparam int LOCK_HOLD_DEF = 16;

endpackage

// File: rtl/nubus_master_sched_if.sv
// Local requester / master-port / status bundle of the scheduler.
interface nubus_master_sched_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*32-1:0] req_addr;
    logic [NREQ*32-1:0] req_wdata;
    logic [NREQ*4-1:0]  req_write;
    logic [NREQ-1:0]    req_lock;
    logic [NREQ-1:0]    req_ready;
    logic [31:0]        req_rdata;
    logic               req_err;

    logic               mst_valid;
    logic [31:0]        mst_addr;
    logic [31:0]        mst_wdata;
    logic [3:0]         mst_write;
    logic               mst_lock;
    logic               mst_ready;
    logic [31:0]        mst_rdata;
    logic               mst_error;

    logic [NREQ-1:0]    sch_grant;
    logic               sch_timeout;

    modport master (
        input  req_valid, req_addr, req_wdata, req_write, req_lock,
        output req_ready, req_rdata, req_err,
        output mst_valid, mst_addr, mst_wdata, mst_write, mst_lock,
        input  mst_ready, mst_rdata, mst_error,
        output sch_grant, sch_timeout
    );

    modport slave (
        output req_valid, req_addr, req_wdata, req_write, req_lock,
        input  req_ready, req_rdata, req_err,
        input  mst_valid, mst_addr, mst_wdata, mst_write, mst_lock,
        output mst_ready, mst_rdata, mst_error,
        input  sch_grant, sch_timeout
    );
endinterface

// File: rtl/nubus_rr_arbiter.sv
// Combinational rotating-priority picker: search starts one past ptr_i.
module nubus_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [PW-1:0]   idx_o,
    output logic            any_o
);

    int cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = 0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = (int'(ptr_i) + i) % NREQ;
            if (!any_o && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                idx_o         = PW'(cand);
                any_o         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nubus_master_sched.sv
// Round-robin scheduler of local requesters onto the single NuBus master port,
// with locked-sequence retention and a per-transaction watchdog.
module nubus_master_sched
    import nubus_sched_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int TMO_W     = TMO_W_DEF,
    parameter int LOCK_HOLD = LOCK_HOLD_DEF
) (
    input  logic                 nub_clkn,
    input  logic                 nub_resetn,
    nubus_master_sched_if.master bus
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD + 1) : 1;

    sched_state_e     state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [3:0]       write_q, write_d;
    logic             lock_q, lock_d;
    logic             relock_q, relock_d;
    logic             err_q, err_d;
    logic             tmo_q, tmo_d;
    logic [TMO_W-1:0] wdt_q, wdt_d;
    logic [HW-1:0]    hold_q, hold_d;

    logic [NREQ-1:0]  arb_grant;
    logic [PW-1:0]    arb_idx;
    logic             arb_any;
    logic [PW-1:0]    sel_idx;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_wdata;
    logic [3:0]       sel_write;
    logic             sel_lock;

    nubus_rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req_i   (bus.req_valid),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    // In LHOLD the pointer still names the lock owner, so it doubles as the latch select.
    always_comb begin
        sel_idx   = (state_q == ST_IDLE) ? arb_idx : ptr_q;
        sel_addr  = bus.req_addr[32*int'(sel_idx) +: 32];
        sel_wdata = bus.req_wdata[32*int'(sel_idx) +: 32];
        sel_write = bus.req_write[4*int'(sel_idx) +: 4];
        sel_lock  = bus.req_lock[sel_idx];
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        lock_d   = lock_q;
        relock_d = relock_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        tmo_d    = 1'b0;
        wdt_d    = wdt_q;
        hold_d   = hold_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    state_d  = ST_BUSY;
                    grant_d  = arb_grant;
                    ptr_d    = arb_idx;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                    write_d  = sel_write;
                    lock_d   = sel_lock;
                    relock_d = 1'b0;
                    wdt_d    = '0;
                end
            end
            ST_BUSY: begin
                if (bus.mst_ready) begin
                    state_d = ST_RESP;
                    rdata_d = bus.mst_rdata;
                    err_d   = bus.mst_error;
                end else if (&wdt_q) begin
                    state_d = ST_RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                end else begin
                    wdt_d = wdt_q + TMO_W'(1);
                end
            end
            ST_RESP: begin
                wdt_d  = '0;
                hold_d = '0;
                if (lock_q && !err_q) begin
                    state_d = ST_LHOLD;
                end else begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
            ST_LHOLD: begin
                if (bus.req_valid[ptr_q]) begin
                    state_d  = ST_BUSY;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                    write_d  = sel_write;
                    lock_d   = sel_lock;
                    relock_d = 1'b1;
                    wdt_d    = '0;
                end else if (hold_q == HW'(LOCK_HOLD - 1)) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    lock_d  = 1'b0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(negedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            state_q  <= ST_IDLE;
            ptr_q    <= PW'(NREQ - 1);
            grant_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= '0;
            lock_q   <= 1'b0;
            relock_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
            wdt_q    <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
            lock_q   <= lock_d;
            relock_q <= relock_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
            wdt_q    <= wdt_d;
            hold_q   <= hold_d;
        end
    end

    assign bus.mst_valid   = (state_q == ST_BUSY);
    assign bus.mst_addr    = addr_q;
    assign bus.mst_wdata   = wdata_q;
    assign bus.mst_write   = write_q;
    assign bus.mst_lock    = ((state_q == ST_BUSY) && (lock_q || relock_q)) ||
                             (state_q == ST_LHOLD);
    assign bus.sch_grant   = grant_q;
    assign bus.sch_timeout = tmo_q;
    assign bus.req_ready   = (state_q == ST_RESP) ? grant_q : '0;
    assign bus.req_rdata   = (state_q == ST_RESP) ? rdata_q : '0;
    assign bus.req_err     = (state_q == ST_RESP) && err_q;

endmodule

// File: tb/tb_nubus_master_sched.sv
// Directed bench for nubus_master_sched: NREQ=2, TMO_W=4, LOCK_HOLD=6.
module tb_nubus_master_sched;

    localparam int NREQ      = 2;
    localparam int TMO_W     = 4;
    localparam int LOCK_HOLD = 6;

    logic nub_clkn;
    logic nub_resetn;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cnt;

    nubus_master_sched_if #(.NREQ(NREQ)) bus ();

    nubus_master_sched #(
        .NREQ      (NREQ),
        .TMO_W     (TMO_W),
        .LOCK_HOLD (LOCK_HOLD)
    ) dut (
        .nub_clkn   (nub_clkn),
        .nub_resetn (nub_resetn),
        .bus        (bus.master)
    );

    initial begin
        nub_clkn = 1'b1;
        forever #5 nub_clkn = ~nub_clkn;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, summary not printed");
        $fatal(1, "time limit");
    end

    // Registers move on the falling edge of nub_clkn; sample/drive 1 ns later.
    task automatic tick();
        @(negedge nub_clkn);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        nub_resetn    = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_write = '0;
        bus.req_lock  = '0;
        bus.mst_ready = 1'b0;
        bus.mst_rdata = '0;
        bus.mst_error = 1'b0;
        #12;
        chk("rst_mst_valid", bus.mst_valid, 0);
        chk("rst_grant", bus.sch_grant, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_mst_addr", bus.mst_addr, 0);
        nub_resetn = 1'b1;
        tick();

        // Both requesting after reset: requester 0 first, then 1.
        bus.req_addr  = {32'hA1A1_0004, 32'hA0A0_0000};
        bus.req_valid = 2'b11;
        tick();
        chk("rr_grant0", bus.sch_grant, 2'b01);
        chk("rr_valid0", bus.mst_valid, 1);
        chk("rr_addr0", bus.mst_addr, 32'hA0A0_0000);
        bus.mst_ready = 1'b1;
        tick();
        chk("rr_ready0", bus.req_ready, 2'b01);
        chk("rr_valid_low", bus.mst_valid, 0);
        bus.mst_ready = 1'b0;
        bus.req_valid = 2'b10;
        tick();
        chk("rr_idle_grant", bus.sch_grant, 0);
        tick();
        chk("rr_grant1", bus.sch_grant, 2'b10);
        chk("rr_addr1", bus.mst_addr, 32'hA1A1_0004);
        bus.mst_ready = 1'b1;
        tick();
        chk("rr_ready1", bus.req_ready, 2'b10);
        bus.mst_ready = 1'b0;
        bus.req_valid = 2'b00;
        tick();

        // Read with 3-cycle master latency.
        bus.req_addr[31:0] = 32'hF500_0010;
        bus.req_write      = '0;
        bus.req_valid      = 2'b01;
        tick();
        chk("rd_grant", bus.sch_grant, 2'b01);
        chk("rd_addr", bus.mst_addr, 32'hF500_0010);
        chk("rd_write", bus.mst_write, 0);
        tick();
        tick();
        chk("rd_valid_wait", bus.mst_valid, 1);
        bus.mst_ready = 1'b1;
        bus.mst_rdata = 32'hDEAD_BEEF;
        tick();
        chk("rd_ready", bus.req_ready, 2'b01);
        chk("rd_rdata", bus.req_rdata, 32'hDEAD_BEEF);
        chk("rd_err", bus.req_err, 0);
        bus.mst_ready = 1'b0;
        bus.req_valid = 2'b00;
        tick();
        chk("rd_ready_gone", bus.req_ready, 0);

        // Watchdog: requester 1 write, master never answers.
        bus.req_addr[63:32]  = 32'hB000_0100;
        bus.req_wdata[63:32] = 32'h5555_AAAA;
        bus.req_write[7:4]   = 4'hF;
        bus.req_valid        = 2'b10;
        tick();
        chk("to_grant", bus.sch_grant, 2'b10);
        chk("to_write", bus.mst_write, 4'hF);
        chk("to_wdata", bus.mst_wdata, 32'h5555_AAAA);
        cnt = 0;
        while (bus.mst_valid && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("to_valid_cycles", cnt, 16);
        chk("to_pulse", bus.sch_timeout, 1);
        chk("to_ready", bus.req_ready, 2'b10);
        chk("to_err", bus.req_err, 1);
        bus.req_valid = 2'b00;
        tick();
        chk("to_pulse_end", bus.sch_timeout, 0);

        // mst_ready on the watchdog's terminal cycle wins.
        bus.req_write = '0;
        bus.req_valid = 2'b01;
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("tc_still_busy", bus.mst_valid, 1);
        bus.mst_ready = 1'b1;
        bus.mst_rdata = 32'h1234_5678;
        tick();
        chk("tc_ready", bus.req_ready, 2'b01);
        chk("tc_no_timeout", bus.sch_timeout, 0);
        chk("tc_err", bus.req_err, 0);
        chk("tc_rdata", bus.req_rdata, 32'h1234_5678);
        bus.mst_ready = 1'b0;
        bus.req_valid = 2'b00;
        tick();

        // Error response drops a requested lock.
        bus.req_lock  = 2'b10;
        bus.req_valid = 2'b10;
        tick();
        chk("el_grant", bus.sch_grant, 2'b10);
        chk("el_lock", bus.mst_lock, 1);
        bus.mst_ready = 1'b1;
        bus.mst_error = 1'b1;
        tick();
        chk("el_err", bus.req_err, 1);
        bus.mst_ready = 1'b0;
        bus.mst_error = 1'b0;
        tick();
        chk("el_idle_grant", bus.sch_grant, 0);
        chk("el_idle_lock", bus.mst_lock, 0);
        bus.req_valid = 2'b00;
        tick();

        // Locked sequence from requester 1 keeps out pending requester 0.
        bus.req_addr  = {32'hB000_0001, 32'hC000_0000};
        bus.req_lock  = 2'b10;
        bus.req_valid = 2'b10;
        tick();
        chk("lk_grant1", bus.sch_grant, 2'b10);
        bus.req_valid = 2'b11;
        bus.mst_ready = 1'b1;
        tick();
        chk("lk_ready1", bus.req_ready, 2'b10);
        bus.mst_ready       = 1'b0;
        bus.req_addr[63:32] = 32'hB000_0002;
        tick();
        chk("lk_hold_lock", bus.mst_lock, 1);
        chk("lk_hold_valid", bus.mst_valid, 0);
        tick();
        chk("lk_second_grant", bus.sch_grant, 2'b10);
        chk("lk_second_addr", bus.mst_addr, 32'hB000_0002);
        bus.mst_ready = 1'b1;
        tick();
        chk("lk_second_ready", bus.req_ready, 2'b10);
        bus.mst_ready       = 1'b0;
        bus.req_addr[63:32] = 32'hB000_0003;
        bus.req_lock        = 2'b00;
        tick();
        tick();
        chk("lk_third_addr", bus.mst_addr, 32'hB000_0003);
        chk("lk_third_lock", bus.mst_lock, 1);
        bus.mst_ready = 1'b1;
        tick();
        chk("lk_third_ready", bus.req_ready, 2'b10);
        bus.mst_ready = 1'b0;
        bus.req_valid = 2'b01;
        tick();
        chk("lk_released", bus.sch_grant, 0);
        tick();
        chk("lk_req0_grant", bus.sch_grant, 2'b01);
        chk("lk_req0_addr", bus.mst_addr, 32'hC000_0000);
        bus.mst_ready = 1'b1;
        tick();
        chk("lk_req0_ready", bus.req_ready, 2'b01);
        bus.mst_ready = 1'b0;
        bus.req_valid = 2'b00;
        tick();

        // Lock expires when the owner stays silent for LOCK_HOLD cycles.
        bus.req_lock  = 2'b10;
        bus.req_valid = 2'b10;
        tick();
        chk("lx_grant1", bus.sch_grant, 2'b10);
        bus.mst_ready = 1'b1;
        tick();
        bus.mst_ready = 1'b0;
        bus.req_valid = 2'b01;
        tick();
        cnt = 0;
        while (bus.mst_lock && !bus.mst_valid && cnt < 20) begin
            cnt++;
            tick();
        end
        chk("lx_hold_cycles", cnt, LOCK_HOLD);
        chk("lx_lock_drop", bus.mst_lock, 0);
        chk("lx_idle_grant", bus.sch_grant, 0);
        tick();
        chk("lx_req0_grant", bus.sch_grant, 2'b01);
        chk("lx_req0_nolock", bus.mst_lock, 0);

        // Asynchronous reset while BUSY.
        tick();
        bus.mst_ready = 1'b1;
        #2;
        nub_resetn = 1'b0;
        #1;
        chk("ar_mst_valid", bus.mst_valid, 0);
        chk("ar_grant", bus.sch_grant, 0);
        chk("ar_req_ready", bus.req_ready, 0);
        bus.mst_ready = 1'b0;
        bus.req_valid = 2'b00;
        tick();
        #2;
        nub_resetn = 1'b1;
        tick();
        chk("ar_no_stale_ready", bus.req_ready, 0);
        chk("ar_idle_valid", bus.mst_valid, 0);
        tick();
        chk("ar_no_stale_ready2", bus.req_ready, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
